riscv_lsu: RTL and testbench

//  Load-store unit: the responder for the decoder's mem_req/mem_we/mem_size requests.
//  - Drives the data-memory bus: word address, byte enables, replicated write data.
//  - Returns sign/zero-extended load data.
//  - Holds the core through mem_stall_req until the access completes.
//  - Sits between the execute stage (address = ALU result, data = RS2) and data memory.
//

---
 rtl/riscv_lsu_if.sv | 31 +++
 rtl/riscv_lsu.sv | 138 +++++++++++++
 tb/tb_riscv_lsu.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_lsu_if.sv
// Signal bundle between the load-store unit, the core pipeline and the data-memory bus.
// The LSU uses the slave view; the core/memory environment uses the master view.
interface riscv_lsu_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_req_o;
  logic        lsu_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_req_o, lsu_err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o,
           mem_wd_o
  );

  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_req_o, lsu_err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o,
           mem_wd_o
  );
endinterface

// File: rtl/riscv_lsu.sv
// RISC-V load-store unit: byte-lane steering, load extension, bus timeout and core stall.
// Define LSU_MISALIGN_TRAP_EN to refuse misaligned half/word accesses with an error response.
module riscv_lsu #(
  parameter int TIMEOUT = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  riscv_lsu_if.slave lsu
);
  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state_q, state_d;
  logic [31:0]      rd_q, rd_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req;

  logic [1:0]  off;
  logic        is_byte, is_half, is_signed, misalign, timeout_hit;
  logic [3:0]  be;
  logic [31:0] wd, ld_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Sizes 2/3/6/7 all fall through to word.
  assign off       = lsu.core_addr_i[1:0];
  assign is_byte   = (lsu.core_size_i[1:0] == 2'd0);
  assign is_half   = (lsu.core_size_i[1:0] == 2'd1);
  assign is_signed = ~lsu.core_size_i[2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (is_half & off[0]) | (~is_byte & ~is_half & (off != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    be = 4'hF;
    wd = lsu.core_wd_i;
    if (is_byte) begin
      be = 4'b0001 << off;
      wd = {4{lsu.core_wd_i[7:0]}};
    end else if (is_half) begin
      be = 4'b0011 << {off[1], 1'b0};
      wd = {2{lsu.core_wd_i[15:0]}};
    end
  end

  always_comb begin
    ld_byte = lsu.mem_rd_i[{off, 3'b000} +: 8];
    ld_half = off[1] ? lsu.mem_rd_i[31:16] : lsu.mem_rd_i[15:0];
    ld_ext  = lsu.mem_rd_i;
    if (is_byte)      ld_ext = {{24{is_signed & ld_byte[7]}}, ld_byte};
    else if (is_half) ld_ext = {{16{is_signed & ld_half[15]}}, ld_half};
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lsu.core_req_i) begin
          if (misalign) begin
            rd_d    = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            req = 1'b1;
            if (lsu.mem_ready_i) begin
              if (!lsu.core_we_i) rd_d = ld_ext;
              state_d = RESP;
            end else begin
              cnt_d   = '0;
              state_d = ACCESS;
            end
          end
        end
      end
      ACCESS: begin
        req   = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (lsu.mem_ready_i) begin
          if (!lsu.core_we_i) rd_d = ld_ext;
          state_d = RESP;
        end else if (timeout_hit) begin
          rd_d    = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (!lsu.core_req_i) begin
          state_d = DRAIN;
        end
      end
      // An abandoned access still owns the bus until memory acknowledges it.
      DRAIN: begin
        req = 1'b1;
        if (lsu.mem_ready_i) state_d = IDLE;
      end
      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset is synchronous, so outputs are gated directly to read 0 in the cycle it is applied.
  assign lsu.mem_req_o        = ~rst_i & req;
  assign lsu.mem_we_o         = ~rst_i & req & lsu.core_we_i;
  assign lsu.mem_be_o         = rst_i ? 4'h0 : be;
  assign lsu.mem_addr_o       = rst_i ? 32'h0 : {lsu.core_addr_i[31:2], 2'b00};
  assign lsu.mem_wd_o         = rst_i ? 32'h0 : wd;
  assign lsu.core_stall_req_o = ~rst_i & lsu.core_req_i & (state_q != RESP);
  assign lsu.lsu_err_o        = ~rst_i & err_q & (state_q == RESP);
  assign lsu.core_rd_o        = rst_i ? 32'h0 : rd_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// Randomised and directed bench for riscv_lsu against a transaction-level model of the LSU.
// Honours LSU_MISALIGN_TRAP_EN when it is defined for the whole build.
module tb_riscv_lsu;
  localparam int TIMEOUT = 256;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct {
    logic        req, we, stall, err, chk_bus, chk_rd;
    logic [3:0]  be;
    logic [31:0] addr, wd, rd;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_i = 1'b1;

  riscv_lsu_if lsu ();
  riscv_lsu #(.TIMEOUT(TIMEOUT)) dut (.clk_i(clk), .rst_i(rst_i), .lsu(lsu));

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  exp_t        exp_c;
  logic        exp_valid = 1'b0;
  logic [31:0] model_rd  = '0;

  logic        snap_req, snap_we, snap_err;
  logic [3:0]  snap_be;
  logic [31:0] snap_addr, snap_wd, snap_rd;
  logic        first_req, first_we, resp_err;
  logic [3:0]  first_be;
  logic [31:0] first_addr, first_wd, resp_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int width_of(input logic [2:0] size);
    case (size[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int start_of(input logic [2:0] size, input logic [31:0] addr);
    int w;
    w = width_of(size);
    return (int'(addr[1:0]) / w) * w;
  endfunction

  function automatic bit model_trap(input logic [2:0] size, input logic [31:0] addr);
    int w;
    w = width_of(size);
    return TRAP_EN && (w > 1) && ((int'(addr[1:0]) % w) != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] size, input logic [31:0] addr);
    int w, s;
    logic [3:0] r;
    w = width_of(size);
    s = start_of(size, addr);
    r = '0;
    for (int i = 0; i < 4; i++) if (i >= s && i < s + w) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] size, input logic [31:0] wd);
    int w;
    logic [31:0] r;
    w = width_of(size);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % w) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] size, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int w, s;
    longint v, lim;
    w = width_of(size);
    s = start_of(size, addr);
    v = 0;
    for (int i = 0; i < w; i++) v += longint'(rd[8*(s+i) +: 8]) << (8*i);
    lim = longint'(1) << (8*w - 1);
    if (w < 4 && !size[2] && v >= lim) v -= lim * 2;
    return v[31:0];
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_i) begin
      check("rst_ctl", 32'({lsu.mem_req_o, lsu.mem_we_o, lsu.core_stall_req_o, lsu.lsu_err_o,
                            lsu.mem_be_o}), 32'd0);
      check("rst_addr", lsu.mem_addr_o, 32'd0);
      check("rst_wd", lsu.mem_wd_o, 32'd0);
      check("rst_rd", lsu.core_rd_o, 32'd0);
    end else if (exp_valid) begin
      check("mem_req", 32'(lsu.mem_req_o), 32'(exp_c.req));
      check("mem_we", 32'(lsu.mem_we_o), 32'(exp_c.we));
      check("stall", 32'(lsu.core_stall_req_o), 32'(exp_c.stall));
      check("lsu_err", 32'(lsu.lsu_err_o), 32'(exp_c.err));
      if (exp_c.chk_bus) begin
        check("mem_be", 32'(lsu.mem_be_o), 32'(exp_c.be));
        check("mem_addr", lsu.mem_addr_o, exp_c.addr);
        check("mem_wd", lsu.mem_wd_o, exp_c.wd);
      end
      if (exp_c.chk_rd) check("core_rd", lsu.core_rd_o, exp_c.rd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    snap_req  = lsu.mem_req_o;
    snap_we   = lsu.mem_we_o;
    snap_err  = lsu.lsu_err_o;
    snap_be   = lsu.mem_be_o;
    snap_addr = lsu.mem_addr_o;
    snap_wd   = lsu.mem_wd_o;
    snap_rd   = lsu.core_rd_o;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_core(input logic req, input logic we, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wd);
    lsu.core_req_i  = req;
    lsu.core_we_i   = we;
    lsu.core_size_i = size;
    lsu.core_addr_i = addr;
    lsu.core_wd_i   = wd;
  endtask

  task automatic idle(input int k);
    exp_t e;
    e.req = 1'b0; e.we = 1'b0; e.stall = 1'b0; e.err = 1'b0;
    e.chk_bus = 1'b0; e.chk_rd = 1'b1; e.be = '0; e.addr = '0; e.wd = '0;
    for (int j = 0; j < k; j++) begin
      drive_core(1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
      lsu.mem_ready_i = 1'($urandom);
      lsu.mem_rd_i    = $urandom;
      e.rd      = model_rd;
      exp_c     = e;
      exp_valid = 1'b1;
      step();
    end
  endtask

  // One complete access: memory answers on cycle d counted from the request cycle.
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdata, input int d);
    exp_t e;
    bit   trap, tmo;
    int   n;
    trap = model_trap(size, addr);
    tmo  = !trap && (TIMEOUT != 0) && (d > TIMEOUT);
    n    = trap ? 1 : (tmo ? TIMEOUT + 1 : d + 1);
    e.req = !trap; e.we = we & !trap; e.stall = 1'b1; e.err = 1'b0;
    e.chk_bus = !trap; e.chk_rd = 1'b0; e.rd = '0;
    e.be = model_be(size, addr); e.addr = {addr[31:2], 2'b00}; e.wd = model_wd(size, wd);
    for (int j = 0; j < n; j++) begin
      drive_core(1'b1, we, size, addr, wd);
      lsu.mem_ready_i = !trap && (j == d);
      lsu.mem_rd_i    = (j == d) ? rdata : $urandom;
      exp_c     = e;
      exp_valid = 1'b1;
      step();
      if (j == 0) begin
        first_req = snap_req; first_we = snap_we; first_be = snap_be;
        first_addr = snap_addr; first_wd = snap_wd;
      end
    end
    if (trap || tmo) model_rd = '0;
    else if (!we)    model_rd = model_load(size, addr, rdata);
    lsu.mem_ready_i = 1'b0;
    lsu.mem_rd_i    = $urandom;
    e.req = 1'b0; e.we = 1'b0; e.stall = 1'b0; e.err = trap || tmo;
    e.chk_bus = 1'b0; e.chk_rd = 1'b1; e.rd = model_rd;
    exp_c = e;
    step();
    resp_rd  = snap_rd;
    resp_err = snap_err;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    drive_core(1'b1, 1'b1, 3'd2, 32'h1234_5678, 32'hFFFF_FFFF);
    lsu.mem_ready_i = 1'b1;
    lsu.mem_rd_i    = 32'hFFFF_FFFF;
    step();
    step();
    rst_i = 1'b0;
    idle(2);

    access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    check("lw_be", 32'(first_be), 32'hF);
    check("lw_rd", resp_rd, 32'hDEAD_BEEF);
    check("lw_err", 32'(resp_err), 32'd0);
    idle(1);
    access(1'b0, 3'd0, 32'h103, 32'h0, 32'h8012_3456, 1);
    check("lb_rd", resp_rd, 32'hFFFF_FF80);
    access(1'b0, 3'd4, 32'h103, 32'h0, 32'h8012_3456, 0);
    check("lbu_rd", resp_rd, 32'h0000_0080);
    access(1'b1, 3'd1, 32'h102, 32'h1234_ABCD, $urandom, 2);
    check("sh_be", 32'(first_be), 32'hC);
    check("sh_wd", first_wd, 32'hABCD_ABCD);
    check("sh_we", 32'(first_we), 32'd1);
    check("sh_rd_hold", resp_rd, 32'h0000_0080);
    access(1'b0, 3'd2, 32'h500, 32'h0, $urandom, 300);
    check("tmo_err", 32'(resp_err), 32'd1);
    check("tmo_rd", resp_rd, 32'd0);
    access(1'b0, 3'd2, 32'h504, 32'h0, 32'hCAFE_F00D, TIMEOUT);
    check("late_err", 32'(resp_err), 32'd0);
    check("late_rd", resp_rd, 32'hCAFE_F00D);
    idle(1);
    access(1'b0, 3'd2, 32'h101, 32'h0, 32'h1122_3344, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_req", 32'(first_req), 32'd0);
    check("mis_err", 32'(resp_err), 32'd1);
    check("mis_rd", resp_rd, 32'd0);
`else
    check("mis_be", 32'(first_be), 32'hF);
    check("mis_addr", first_addr, 32'h100);
    check("mis_err", 32'(resp_err), 32'd0);
    check("mis_rd", resp_rd, 32'h1122_3344);
`endif

    // Core abandons a load mid-access, then issues a store while the bus drains.
    e.err = 1'b0; e.rd = model_rd;
    for (int j = 0; j < 6; j++) begin
      lsu.mem_ready_i = (j == 5);
      lsu.mem_rd_i    = $urandom;
      if (j < 2) begin
        drive_core(1'b1, 1'b0, 3'd2, 32'h200, 32'h0);
        e.req = 1'b1; e.we = 1'b0; e.stall = 1'b1; e.chk_bus = 1'b1; e.chk_rd = 1'b0;
        e.be = 4'hF; e.addr = 32'h200; e.wd = 32'h0;
      end else if (j == 2) begin
        drive_core(1'b0, 1'b0, 3'd2, 32'h200, 32'h0);
        e.req = 1'b1; e.we = 1'b0; e.stall = 1'b0; e.chk_bus = 1'b0; e.chk_rd = 1'b1;
      end else begin
        drive_core(1'b1, 1'b1, 3'd0, 32'h301, 32'h55);
        e.req = 1'b1; e.we = 1'b1; e.stall = 1'b1; e.chk_bus = 1'b0; e.chk_rd = 1'b1;
      end
      exp_c = e;
      step();
    end
    access(1'b1, 3'd0, 32'h301, 32'h55, $urandom, 1);
    check("drain_be", 32'(first_be), 32'h2);
    check("drain_wd", first_wd, 32'h5555_5555);

    for (int i = 0; i < 150; i++) begin
      access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)));
      idle(int'($urandom_range(0, 2)));
    end

    // Reset in the middle of an outstanding load.
    access(1'b0, 3'd2, 32'h600, 32'h0, 32'h7777_1234, 0);
    e.req = 1'b1; e.we = 1'b0; e.stall = 1'b1; e.err = 1'b0; e.chk_bus = 1'b1;
    e.chk_rd = 1'b0; e.be = 4'hF; e.addr = 32'h400; e.wd = 32'h0; e.rd = '0;
    for (int j = 0; j < 3; j++) begin
      drive_core(1'b1, 1'b0, 3'd2, 32'h400, 32'h0);
      lsu.mem_ready_i = 1'b0;
      lsu.mem_rd_i    = $urandom;
      exp_c = e;
      step();
    end
    rst_i = 1'b1;
    step();
    rst_i    = 1'b0;
    model_rd = '0;
    idle(3);

    exp_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
